// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-access constants, FSM state type and
// small decode helpers for the data-memory access unit.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  function automatic logic f3_legal(
    input logic [2:0] f3,
    input logic       we,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (f3 == F3_B):  ok = 1'b1;
      (f3 == F3_H):  ok = !a[0];
      (f3 == F3_W):  ok = (a == 2'b00);
      (f3 == F3_BU): ok = !we;
      (f3 == F3_HU): ok = !we && !a[0];
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] f3_be(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (f3[1:0] == 2'b00): be = 4'b0001 << a;
      (f3[1:0] == 2'b01): be = 4'b0011 << a;
      default:            be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] f3_wdata(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] d;
    d = wd;
    unique case (1'b1)
      (f3[1:0] == 2'b00): d = {4{wd[7:0]}};
      (f3[1:0] == 2'b01): d = {2{wd[15:0]}};
      default:            d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword lane out of a bus word
// and sign- or zero-extends it to 32 bits.
module load_extend
  import rv32i_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    unique case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    unique case (i_f3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store sequencer: legality check, bus request
// with timeout, and extended load write-back.
module dmem_access_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic [31:0]   rdata,
  output logic          rdata_valid,
  output logic          err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata
);

  dmem_state_e   r_state;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_f3;
  logic          r_we;
  logic [15:0]   r_cnt;
  logic          r_tmo;
  logic [31:0]   r_rdata;

  logic          w_idle;
  logic          w_busy;
  logic          w_done;
  logic          w_op;
  logic          w_legal;
  logic          w_start;
  logic          w_last;
  logic [31:0]   w_ext;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_busy  = (r_state == ST_BUSY);
  assign w_done  = (r_state == ST_DONE);
  assign w_op    = mem_wr | mem_rd;
  assign w_legal = f3_legal(funct3, mem_wr, addr[1:0]);
  assign w_start = w_idle & w_op & w_legal;
  assign w_last  = (r_cnt == 16'(TIMEOUT - 1));

  load_extend u_load_extend (
    .i_word (bus_rdata),
    .i_lane (r_addr[1:0]),
    .i_f3   (r_f3),
    .o_data (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_f3    <= funct3;
            r_we    <= mem_wr;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // an ack on the final cycle still wins over the timeout
          if (bus_ack) begin
            if (!r_we) r_rdata <= w_ext;
            r_state <= ST_DONE;
          end else if (w_last) begin
            r_tmo   <= 1'b1;
            r_rdata <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // rst_n gating keeps combinational outputs quiet while reset is held
  assign stall       = rst_n & (w_start | w_busy);
  assign err         = rst_n & ((w_idle & w_op & !w_legal)
                              | (w_done & r_tmo));
  assign rdata_valid = rst_n & w_done & !r_we & !r_tmo;
  assign rdata       = r_rdata;

  assign bus_req   = w_busy;
  assign bus_we    = w_busy & r_we;
  assign bus_addr  = w_busy ? {r_addr[AW-1:2], 2'b00} : '0;
  assign bus_be    = w_busy ? f3_be(r_f3, r_addr[1:0]) : 4'b0000;
  assign bus_wdata = w_busy ? f3_wdata(r_f3, r_wdata) : 32'd0;

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 255, max BUSY cycles awaiting bus_ack before abort (1..65535); AW, 32, address width.
REQ-002 Clocking SHALL be exactly: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 mem_rd  in  1  MEM-stage load request from control decode.
REQ-006 mem_wr  in  1  MEM-stage store request; dominates mem_rd (stores arrive with both high).
REQ-007 funct3  in  3  access width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 addr  in  AW  byte address from ALU.
REQ-009 wdata  in  32  store data (rs2).
REQ-010 stall  out  1  hold pipeline while access in progress.
REQ-011 rdata  out  32  extended load result to WB mux.
REQ-012 rdata_valid  out  1  one-cycle pulse: rdata valid.
REQ-013 err  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout.
REQ-014 bus_req, bus_we  out  1 each  memory request / write strobe.
REQ-015 bus_addr  out  AW  word-aligned address (bits [1:0] = 0).
REQ-016 bus_be  out  4  byte enables; bus_wdata  out  32  lane-replicated store data.
REQ-017 bus_ack  in  1  memory completion; bus_rdata  in  32  read word, valid with bus_ack.

Function
REQ-018 FSM SHALL have states IDLE, BUSY, DONE.
REQ-019 IDLE: op = mem_wr | mem_rd; legal op -> capture addr/wdata/funct3/we, go BUSY; illegal op -> err pulse this cycle, stay IDLE, no bus activity.
REQ-020 stall SHALL equal (IDLE & legal op) | BUSY, combinationally; stall SHALL be 0 in DONE and on illegal op.
REQ-021 BUSY: bus_req=1 with captured bus_we/bus_addr/bus_be/bus_wdata stable until the bus_ack cycle; bus_ack sampled high -> register bus_rdata, go DONE.
REQ-022 Minimum latency SHALL be 2 cycles request-to-DONE (ack in first BUSY cycle accepted).
REQ-023 DONE: rdata_valid=1 for loads only; go IDLE unconditionally; inputs in the following IDLE cycle belong to the next instruction.
REQ-024 Legality: w requires addr[1:0]=0; h/hu require addr[0]=0; stores accept funct3 000/001/010 only; loads reject 011/110/111.
REQ-025 bus_be: b -> 0001<<addr[1:0]; h -> 0011<<addr[1:0]; w -> 1111; same rule for loads.
REQ-026 bus_wdata: b -> byte replicated x4; h -> halfword x2; w -> as-is.
REQ-027 Load extension: b/h sign-extend, bu/hu zero-extend the lane selected by addr[1:0]/addr[1]; w passes through.
REQ-028 Timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; at TIMEOUT -> DONE, err=1, rdata=0, rdata_valid=0, bus_req drops.
REQ-029 bus_ack outside BUSY SHALL be ignored; rdata SHALL hold its value except on DONE update.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counter 0, rdata 0, and all outputs 0 (stall, rdata_valid, err, bus_*).
REQ-031 Reset during BUSY SHALL drop bus_req asynchronously; no rdata_valid or err SHALL follow.

Structure
REQ-032 Package rv32i_pkg SHALL hold funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state enum.
REQ-033 Sub-module load_extend (combinational lane select + sign/zero extend) SHALL be instantiated once.

Verification
REQ-034 sw: mem_rd=1, mem_wr=1, addr=0x104, wdata=0xDEADBEEF, ack after 3 cycles -> bus_we=1, be=1111, addr=0x104, stall 4 cycles, no rdata_valid.
REQ-035 lb: addr=0x203, bus_rdata=0x80112233, ack immediate -> rdata=0xFFFFFF80, rdata_valid one pulse, be=1000.
REQ-036 lhu: addr=0x202, bus_rdata=0x8001ABCD -> rdata=0x00008001; sb addr=0x1, wdata=0x5A -> be=0010, bus_wdata=0x5A5A5A5A.
REQ-037 lw addr=0x102 -> err pulse, stall=0, bus_req never high.
REQ-038 TIMEOUT=4, no ack -> bus_req 4 cycles, then err pulse, rdata=0; rst_n low mid-BUSY -> bus_req falls same cycle, no err.
